// File: rtl/uss_ranging_ctrl.sv
// uss_ranging_ctrl
// Runs one HC-SR04 ranging cycle at a time: trigger pulse, wait for the echo
// to rise, time the echo width, give up after a timeout, then hold off before
// the sensor may be fired again. Supports single-shot (start_i) and
// free-running (cont_en_i) operation. All outputs are registered.
// state_o exposes the FSM state for debug and checkers.

module uss_ranging_ctrl #(
   parameter int TRIG_CYCLES    = 1000,
   parameter int TIMEOUT_CYCLES = 3800000,
   parameter int HOLDOFF_CYCLES = 6000000,
   parameter int CNT_W          = 24
) (
   input  logic             ACLK,
   input  logic             ARESET,
   input  logic             start_i,
   input  logic             cont_en_i,
   input  logic             abort_i,
   input  logic             echo_i,
   output logic             trig_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             timeout_o,
   output logic [CNT_W-1:0] width_o,
   output logic [15:0]      meas_cnt_o,
   output logic [2:0]       state_o
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_TRIG      = 3'd1,
      S_WAIT_RISE = 3'd2,
      S_MEASURE   = 3'd3,
      S_HOLDOFF   = 3'd4
   } state_t;

   // One phase counter is shared by the trigger pulse and the hold-off gap,
   // so it is sized for the longer of the two.
   localparam int PH_MAX = (TRIG_CYCLES > HOLDOFF_CYCLES) ? TRIG_CYCLES : HOLDOFF_CYCLES;
   localparam int PH_W   = $clog2(PH_MAX + 1);

   localparam logic [PH_W-1:0]  TRIG_LAST = PH_W'(TRIG_CYCLES - 1);
   localparam logic [PH_W-1:0]  HOLD_LAST = PH_W'(HOLDOFF_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] ALL_ONES  = '1;

   state_t           state;
   logic [PH_W-1:0]  ph_cnt;
   logic [CNT_W-1:0] tmo_cnt;
   logic [CNT_W-1:0] wcnt;

   logic echo_meta;
   logic echo_s;
   logic echo_d;
   logic rise;
   logic fall;

   assign state_o = state;

   // Bring the asynchronous echo pin into the ACLK domain and keep one
   // extra delayed copy for edge detection.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         echo_meta <= 1'b0;
         echo_s    <= 1'b0;
         echo_d    <= 1'b0;
      end else begin
         echo_meta <= echo_i;
         echo_s    <= echo_meta;
         echo_d    <= echo_s;
      end
   end

   // An echo that is already high when waiting starts never produces a
   // rise here, so it cannot be mistaken for a fresh return.
   assign rise = echo_s & ~echo_d;
   assign fall = ~echo_s & echo_d;

   // Ranging sequencer: trigger, wait for rise, measure, hold off.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state      <= S_IDLE;
         trig_o     <= 1'b0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         timeout_o  <= 1'b0;
         width_o    <= '0;
         meas_cnt_o <= '0;
         ph_cnt     <= '0;
         tmo_cnt    <= '0;
         wcnt       <= '0;
      end else begin
         // Result strobes are single-cycle by construction.
         done_o    <= 1'b0;
         timeout_o <= 1'b0;

         if (abort_i && (state != S_IDLE)) begin
            // Abandon the cycle silently; the previous result stays visible.
            state  <= S_IDLE;
            trig_o <= 1'b0;
            busy_o <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  // cont_en_i is only looked at here, so dropping it
                  // mid-cycle lets the running cycle finish first.
                  if (!abort_i && (start_i || cont_en_i)) begin
                     state  <= S_TRIG;
                     trig_o <= 1'b1;
                     busy_o <= 1'b1;
                     ph_cnt <= '0;
                  end
               end

               S_TRIG: begin
                  if (ph_cnt == TRIG_LAST) begin
                     state   <= S_WAIT_RISE;
                     trig_o  <= 1'b0;
                     tmo_cnt <= '0;
                  end else begin
                     ph_cnt <= ph_cnt + PH_W'(1);
                  end
               end

               S_WAIT_RISE: begin
                  if (tmo_cnt == TMO_LAST) begin
                     state     <= S_HOLDOFF;
                     width_o   <= ALL_ONES;
                     done_o    <= 1'b1;
                     timeout_o <= 1'b1;
                     ph_cnt    <= '0;
                  end else begin
                     tmo_cnt <= tmo_cnt + CNT_W'(1);
                     if (rise) begin
                        state <= S_MEASURE;
                        wcnt  <= CNT_W'(1);
                     end
                  end
               end

               S_MEASURE: begin
                  // A fall on the timeout cycle still counts as a valid
                  // measurement, so it is tested first.
                  if (fall) begin
                     state      <= S_HOLDOFF;
                     width_o    <= wcnt;
                     done_o     <= 1'b1;
                     meas_cnt_o <= meas_cnt_o + 16'd1;
                     ph_cnt     <= '0;
                  end else if (tmo_cnt == TMO_LAST) begin
                     state     <= S_HOLDOFF;
                     width_o   <= ALL_ONES;
                     done_o    <= 1'b1;
                     timeout_o <= 1'b1;
                     ph_cnt    <= '0;
                  end else begin
                     tmo_cnt <= tmo_cnt + CNT_W'(1);
                     if (echo_s && (wcnt != ALL_ONES)) begin
                        wcnt <= wcnt + CNT_W'(1);
                     end
                  end
               end

               S_HOLDOFF: begin
                  // start_i is not remembered here; a request during
                  // hold-off is simply lost.
                  if (ph_cnt == HOLD_LAST) begin
                     state  <= S_IDLE;
                     busy_o <= 1'b0;
                  end else begin
                     ph_cnt <= ph_cnt + PH_W'(1);
                  end
               end

               default: begin
                  state  <= S_IDLE;
                  trig_o <= 1'b0;
                  busy_o <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
